// File: rtl/subtrai8_serial.sv
// rtl/subtrai8_serial.sv - bit-serial subtractor S = A - B - Bin, LSB first, one bit per clock.
// Optional signed-overflow output Ov is built only when SUB_OVF_EN is defined.
module subtrai8_serial #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] S,
  output logic             Bo,
  output logic             busy,
  output logic             done
`ifdef SUB_OVF_EN
  ,
  output logic             Ov
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] areg_q, breg_q, s_q;
  logic [CW-1:0]    cnt_q;
  logic             borrow_q, bo_q;
  logic             accept, last_bit;
  logic             a_bit, b_bit, d_bit, borrow_d;

  // A new operation is accepted from IDLE and also from DONE, so back-to-back ops need no idle cycle.
  assign accept   = start && (state_q != RUN);
  assign last_bit = (cnt_q == LAST);

  assign a_bit    = areg_q[0];
  assign b_bit    = breg_q[0];
  assign d_bit    = a_bit ^ b_bit ^ borrow_q;
  assign borrow_d = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    state_d = accept ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

`ifdef SUB_OVF_EN
  logic ov_q;
  assign Ov = ov_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      areg_q   <= '0;
      breg_q   <= '0;
      s_q      <= '0;
      cnt_q    <= '0;
      borrow_q <= 1'b0;
      bo_q     <= 1'b0;
`ifdef SUB_OVF_EN
      ov_q     <= 1'b0;
`endif
    end else if (accept) begin
      areg_q   <= A;
      breg_q   <= B;
      borrow_q <= Bin;
      cnt_q    <= '0;
      s_q      <= '0;
    end else if (state_q == RUN) begin
      areg_q   <= areg_q >> 1;
      breg_q   <= breg_q >> 1;
      borrow_q <= borrow_d;
      s_q      <= {d_bit, s_q[WIDTH-1:1]};
      if (last_bit) begin
        bo_q <= borrow_d;
`ifdef SUB_OVF_EN
        // On the last step the shifted-down bits are the operand MSBs and d_bit is the result MSB.
        ov_q <= (a_bit != b_bit) && (d_bit != a_bit);
`endif
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign S  = s_q;
  assign Bo = bo_q;

endmodule

// File: tb/tb_subtrai8_serial.sv
// tb/tb_subtrai8_serial.sv - directed-vector bench for subtrai8_serial.
module tb_subtrai8_serial;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A, B;
  logic         Bin;
  logic [W-1:0] S;
  logic         Bo, busy, done;
`ifdef SUB_OVF_EN
  logic         Ov;
`endif

  subtrai8_serial #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .Bin   (Bin),
    .S     (S),
    .Bo    (Bo),
    .busy  (busy),
    .done  (done)
`ifdef SUB_OVF_EN
    ,
    .Ov    (Ov)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         bin;
    logic [W-1:0] s;
    logic         bo;
    logic         ov;
  } vec_t;

  vec_t vecs[9];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drives start at the current negedge, then follows the op through RUN into DONE.
  // glitch_at >= 0 pulses start with A=0xAA at that RUN cycle (must be ignored).
  task automatic run_op(input vec_t v, input int glitch_at);
    int busy_bad = 0;
    int done_early = 0;
    A = v.a; B = v.b; Bin = v.bin; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    A = W'($urandom); B = W'($urandom); Bin = 1'($urandom);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      if (busy !== 1'b1) busy_bad++;
      if (done !== 1'b0) done_early++;
      if (i == glitch_at) begin
        start = 1'b1; A = 8'hAA; B = W'($urandom);
      end else begin
        start = 1'b0;
      end
    end
    chk("busy_window", busy_bad, 0);
    chk("no_early_done", done_early, 0);
    @(negedge clk);
    chk("done_pulse", done, 1);
    chk("busy_at_done", busy, 0);
    chk("S", S, v.s);
    chk("Bo", Bo, v.bo);
`ifdef SUB_OVF_EN
    chk("Ov", Ov, v.ov);
`endif
  endtask

  initial begin
    vec_t v2;
    int   dcount;

    vecs[0] = '{8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0};
    vecs[1] = '{8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[3] = '{8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1};
    vecs[4] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    vecs[6] = '{8'h7F, 8'h80, 1'b0, 8'hFF, 1'b1, 1'b1};
    vecs[7] = '{8'h00, 8'hFF, 1'b0, 8'h01, 1'b1, 1'b0};
    vecs[8] = '{8'hFF, 8'h00, 1'b1, 8'hFE, 1'b0, 1'b0};

    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Bin = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_S", S, 0);
    chk("rst_Bo", Bo, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
`ifdef SUB_OVF_EN
    chk("rst_Ov", Ov, 0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i], -1);
      @(negedge clk);
      chk("done_once", done, 0);
      chk("S_hold", S, vecs[i].s);
      chk("Bo_hold", Bo, vecs[i].bo);
    end

    // start pulsed mid-RUN with different operands is ignored
    run_op(vecs[0], 2);
    @(negedge clk);
    chk("glitch_done_once", done, 0);
    chk("glitch_idle", busy, 0);

    // back-to-back: second start presented during the DONE cycle
    run_op(vecs[1], -1);
    v2 = '{8'h20, 8'h10, 1'b0, 8'h10, 1'b0, 1'b0};
    run_op(v2, -1);
    @(negedge clk);
    chk("b2b_done_once", done, 0);

    // reset in the middle of RUN aborts with no done pulse
    A = 8'h03; B = 8'h05; Bin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int i = 0; i < 4; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_S", S, 0);
    chk("abort_Bo", Bo, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    @(negedge clk);
    rst_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < W + 4; i++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) dcount++;
    end
    chk("abort_no_done", dcount, 0);

    run_op(vecs[3], -1);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
